// File: rtl/conv_pkg.sv
// Shared types for the conv window generator: FSM states and the tap
// ordering used on the activation bus.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_e;

  // Bus position of window tap (ky,kx,ch); ky=0 is the top row, kx=0 the left column.
  function automatic int tap_idx(input int ky, input int kx, input int ch,
                                 input int kw, input int nch);
    return (ky * kw + kx) * nch + ch;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row delay line: dout is the element written DEPTH enables ago.
// Read-before-write at a single wrapping address, so it maps onto a RAM.
module conv_line_buffer #(
  parameter int DEPTH = 128,
  parameter int DW    = 48
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] addr_q, addr_d;

  assign dout_o = mem[addr_q];
  assign addr_d = (addr_q == A_LAST) ? '0 : addr_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i)     addr_q <= '0;
    else if (en_i) addr_q <= addr_d;
  end

  always_ff @(posedge clk_i) begin
    if (en_i) mem[addr_q] <= din_i;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream -> 3x3xC sliding windows with zero padding ("same" conv).
// Two line buffers feed the right column of a window shift register.
module conv_window_gen import conv_pkg::*; #(
  parameter int IF_WIDTH    = 128,
  parameter int IF_HEIGHT   = 128,
  parameter int IF_CHANNEL  = 3,
  parameter int IF_BITWIDTH = 16,
  parameter int K_WIDTH     = 3,
  parameter int K_HEIGHT    = 3,
  parameter int IF_PORT     = 27
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              if_start,
  input  logic [IF_CHANNEL*IF_BITWIDTH-1:0] px_data,
  input  logic                              px_valid,
  output logic                              px_ready,
  output logic [IF_PORT*IF_BITWIDTH-1:0]    win_data,
  output logic [IF_PORT-1:0]                win_valid,
  output logic                              win_last,
  output logic                              busy,
  output logic                              done
);

  if (IF_PORT != K_HEIGHT * K_WIDTH * IF_CHANNEL || K_WIDTH != 3 || K_HEIGHT != 3) begin : g_bad_cfg
    $error("conv_window_gen: needs 3x3 kernel and IF_PORT == K_HEIGHT*K_WIDTH*IF_CHANNEL");
  end

  typedef logic [IF_CHANNEL-1:0][IF_BITWIDTH-1:0] px_t;

  localparam int PW = $clog2(IF_WIDTH * IF_HEIGHT + IF_WIDTH + 1);
  localparam int CW = $clog2(IF_WIDTH);
  localparam int RW = $clog2(IF_HEIGHT);
  localparam logic [PW-1:0] P_FIRST   = PW'(IF_WIDTH + 1);
  localparam logic [PW-1:0] P_LAST_PX = PW'(IF_WIDTH * IF_HEIGHT - 1);
  localparam logic [PW-1:0] P_END     = PW'(IF_WIDTH * IF_HEIGHT + IF_WIDTH);
  localparam logic [CW-1:0] C_LAST    = CW'(IF_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST    = RW'(IF_HEIGHT - 1);

  state_e state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic adv, emit;
  logic vld_q, last_q, done_q;
  px_t px_in;
  px_t [K_HEIGHT-2:0] lb_dout;
  px_t [K_HEIGHT-1:0] col_in;
  px_t [K_HEIGHT-1:0][K_WIDTH-1:0] win_q, win_nxt;
  logic [IF_PORT-1:0][IF_BITWIDTH-1:0] wdata_q, wdata_d;
  logic row_top_z, row_bot_z, col_l_z, col_r_z;

  // Accepted pixels and flush bubbles both advance the whole pipeline.
  assign adv   = (state_q == STREAM && px_valid) || (state_q == FLUSH);
  assign emit  = adv && (p_q >= P_FIRST);
  assign px_in = (state_q == STREAM) ? px_t'(px_data) : '0;

  assign col_in[K_HEIGHT-1] = px_in;
  for (genvar i = 0; i < K_HEIGHT - 1; i++) begin : g_lb
    px_t lb_din;
    if (i == 0) begin : g_head
      assign lb_din = px_in;
    end else begin : g_chain
      assign lb_din = lb_dout[i-1];
    end
    conv_line_buffer #(.DEPTH(IF_WIDTH), .DW(IF_CHANNEL * IF_BITWIDTH)) u_lb (
      .clk_i (clk),
      .rst_i (rst),
      .en_i  (adv),
      .din_i (lb_din),
      .dout_o(lb_dout[i])
    );
    assign col_in[K_HEIGHT-2-i] = lb_dout[i];
  end

  always_comb begin
    win_nxt = win_q;
    for (int ky = 0; ky < K_HEIGHT; ky++) begin
      for (int kx = 0; kx < K_WIDTH - 1; kx++) win_nxt[ky][kx] = win_q[ky][kx+1];
      win_nxt[ky][K_WIDTH-1] = col_in[ky];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) win_q <= win_nxt;
  end

  // Edge masks also scrub stale line-buffer data and row-wrap columns.
  assign row_top_z = (r_q == '0);
  assign row_bot_z = (r_q == R_LAST);
  assign col_l_z   = (c_q == '0);
  assign col_r_z   = (c_q == C_LAST);

  always_comb begin
    wdata_d = wdata_q;
    if (emit) begin
      for (int ky = 0; ky < K_HEIGHT; ky++)
        for (int kx = 0; kx < K_WIDTH; kx++)
          for (int ch = 0; ch < IF_CHANNEL; ch++)
            wdata_d[tap_idx(ky, kx, ch, K_WIDTH, IF_CHANNEL)] =
              ((ky == 0 && row_top_z) || (ky == K_HEIGHT - 1 && row_bot_z) ||
               (kx == 0 && col_l_z)   || (kx == K_WIDTH - 1 && col_r_z))
              ? '0 : win_nxt[ky][kx][ch];
    end
  end

  always_comb begin
    p_d = p_q;
    r_d = r_q;
    c_d = c_q;
    if (state_q == IDLE) begin
      p_d = '0;
      r_d = '0;
      c_d = '0;
    end else begin
      if (adv) p_d = (p_q == P_END) ? '0 : p_q + 1'b1;
      if (emit) begin
        c_d = col_r_z ? '0 : c_q + 1'b1;
        if (col_r_z) r_d = row_bot_z ? '0 : r_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      r_q     <= r_d;
      c_q     <= c_d;
      vld_q   <= emit;
      last_q  <= emit && row_bot_z && col_r_z;
      done_q  <= (state_q == DONE);
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_start) state_d = STREAM;
      STREAM:  if (adv && p_q == P_LAST_PX) state_d = FLUSH;
      FLUSH:   if (p_q == P_END) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    px_ready  = (state_q == STREAM);
    busy      = (state_q != IDLE);
    done      = done_q;
    win_last  = last_q;
    win_valid = {IF_PORT{vld_q}};
    win_data  = wdata_q;
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen on a 4x4 frame: a C=1 instance and a C=3 instance
// share stimulus; a scoreboard queue holds the expected windows in order.
module tb_conv_window_gen;

  typedef logic [431:0] v_t;
  typedef logic [8:0][15:0] win_t;
  typedef logic [26:0][15:0] win3_t;
  typedef struct { win_t d; logic last; } exp_t;

  logic clk = 1'b0;
  logic rst, if_start, px_valid;
  logic [15:0] px_data;
  logic [47:0] px_data3;
  logic px_ready, busy, done, win_last;
  logic [143:0] win_data;
  logic [8:0] win_valid;
  logic px_ready3, busy3, done3, win_last3;
  logic [431:0] win_data3;
  logic [26:0] win_valid3;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_window_gen #(.IF_WIDTH(4), .IF_HEIGHT(4), .IF_CHANNEL(1), .IF_BITWIDTH(16),
                    .K_WIDTH(3), .K_HEIGHT(3), .IF_PORT(9)) dut (
    .clk(clk), .rst(rst), .if_start(if_start), .px_data(px_data), .px_valid(px_valid),
    .px_ready(px_ready), .win_data(win_data), .win_valid(win_valid), .win_last(win_last),
    .busy(busy), .done(done));

  conv_window_gen #(.IF_WIDTH(4), .IF_HEIGHT(4), .IF_CHANNEL(3), .IF_BITWIDTH(16),
                    .K_WIDTH(3), .K_HEIGHT(3), .IF_PORT(27)) dut3 (
    .clk(clk), .rst(rst), .if_start(if_start), .px_data(px_data3), .px_valid(px_valid),
    .px_ready(px_ready3), .win_data(win_data3), .win_valid(win_valid3), .win_last(win_last3),
    .busy(busy3), .done(done3));

  task automatic check(input string nm, input v_t act, input v_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic win_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    win_t w;
    w[0] = 16'(a0); w[1] = 16'(a1); w[2] = 16'(a2);
    w[3] = 16'(a3); w[4] = 16'(a4); w[5] = 16'(a5);
    w[6] = 16'(a6); w[7] = 16'(a7); w[8] = 16'(a8);
    return w;
  endfunction

  // Zero-padded 3x3 neighbourhood of centre q; pixel idx carries value base+idx+1.
  function automatic win_t model(input int base, input int q);
    win_t w;
    int r, c, rr, cc;
    w = '0;
    r = q / 4;
    c = q % 4;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++) begin
        rr = r + ky - 1;
        cc = c + kx - 1;
        if (rr >= 0 && rr < 4 && cc >= 0 && cc < 4) w[ky*3+kx] = 16'(base + rr * 4 + cc + 1);
      end
    return w;
  endfunction

  // C=3 sample is (value<<2)|ch at bus position k*3+ch; padded taps stay 0.
  function automatic win3_t expand(input win_t w);
    win3_t x;
    x = '0;
    for (int k = 0; k < 9; k++)
      for (int ch = 0; ch < 3; ch++)
        if (w[k] != 16'd0) x[k*3+ch] = 16'((int'(w[k]) << 2) | ch);
    return x;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_px_ready"}, v_t'(px_ready), v_t'(0));
    check({tag, "_busy"}, v_t'(busy), v_t'(0));
    check({tag, "_done"}, v_t'(done), v_t'(0));
    check({tag, "_win_valid"}, v_t'({win_valid3, win_valid}), v_t'(0));
    check({tag, "_win_last"}, v_t'(win_last), v_t'(0));
    check({tag, "_win_data"}, v_t'(win_data), v_t'(0));
  endtask

  task automatic push_px(input int v);
    int n;
    px_data  = 16'(v);
    px_data3 = {16'((v << 2) | 2), 16'((v << 2) | 1), 16'(v << 2)};
    px_valid = 1'b1;
    n = 0;
    while (!px_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("px_ready_timeout", v_t'(px_ready), v_t'(1));
    @(negedge clk);
  endtask

  task automatic run_frame(input int base, input bit gaps, input bit hold, input int npx);
    exp_t e;
    @(negedge clk);
    for (int q = 0; q < 16; q++) begin
      e.d = model(base, q);
      if (base == 0 && q == 0)   e.d = mk(0, 0, 0, 0, 1, 2, 0, 5, 6);
      if (base == 0 && q == 5)   e.d = mk(1, 2, 3, 5, 6, 7, 9, 10, 11);
      if (base == 0 && q == 15)  e.d = mk(11, 12, 0, 15, 16, 0, 0, 0, 0);
      if (base == 100 && q == 0) e.d = mk(0, 0, 0, 0, 101, 102, 0, 105, 106);
      e.last = (q == 15);
      exp_q.push_back(e);
    end
    if_start = 1'b1;
    @(negedge clk);
    if (!hold) if_start = 1'b0;
    for (int i = 0; i < npx; i++) begin
      if (gaps)
        while ($urandom_range(0, 9) < 4) begin
          px_valid = 1'b0;
          @(negedge clk);
        end
      push_px(base + i + 1);
    end
    if (npx == 16) begin
      // 5 flush cycles, DONE, then the done-pulse cycle; px_valid stays high.
      for (int k = 0; k < 7; k++) begin
        check("flush_px_ready_low", v_t'(px_ready), v_t'(0));
        if (k < 6)  check("flush_win_valid", v_t'(win_valid[0]), v_t'(1));
        if (k == 5) check("last_win_last", v_t'(win_last), v_t'(1));
        if (k == 6) begin
          check("done_pulse", v_t'(done), v_t'(1));
          check("busy_drop", v_t'(busy), v_t'(0));
          if_start = 1'b0;
        end
        @(negedge clk);
      end
      px_valid = 1'b0;
      check("idle_after_done", v_t'({busy, px_ready, done}), v_t'(0));
    end
  endtask

  // Monitor: every presented window is popped from the scoreboard and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (win_valid != 9'd0 || win_valid3 != 27'd0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_window", v_t'(win_data), v_t'(0));
        end else begin
          e = exp_q.pop_front();
          check("win_valid_all9", v_t'(win_valid), v_t'(9'h1ff));
          check("win_valid_all27", v_t'(win_valid3), v_t'(27'h7ffffff));
          check("win_data", v_t'(win_data), v_t'(e.d));
          check("win_data_c3", v_t'(win_data3), v_t'(expand(e.d)));
          check("win_last", v_t'(win_last), v_t'(e.last));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_start = 1'b0;
    px_valid = 1'b0;
    px_data = '0;
    px_data3 = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    run_frame(0, 1'b0, 1'b0, 16);    // basic frame + flush timing
    run_frame(0, 1'b0, 1'b1, 16);    // if_start held through STREAM/FLUSH/DONE
    run_frame(0, 1'b1, 1'b0, 16);    // random px_valid gaps
    run_frame(0, 1'b0, 1'b0, 7);     // aborted by reset below
    px_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    exp_q.delete();
    rst = 1'b0;
    run_frame(100, 1'b1, 1'b0, 16);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", v_t'(exp_q.size()), v_t'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
